// File: rtl/path_trace_monitor.sv
// path_trace_monitor: passive per-router path tracer.
// Watches output-port allocation, follows each granted packet flit by flit,
// and emits one record per completed packet through a small valid/ready FIFO.
// Records that cannot be buffered are counted in a saturating drop counter.
module path_trace_monitor #(
    parameter int NPORT       = 5,
    parameter int FLIT_W      = 16,
    parameter int CAPTURE_IDX = 3,
    parameter int FIFO_DEPTH  = 8,
    parameter int TS_W        = 16
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              enable,
    input  logic [NPORT-1:0]                  h_ack,
    input  logic [$clog2(NPORT)-1:0]          in_port_i,
    input  logic [FLIT_W-1:0]                 address_i,
    input  logic [NPORT-1:0]                  free_i,
    input  logic [NPORT-1:0]                  tx_i,
    input  logic [NPORT-1:0]                  credit_i,
    input  logic [NPORT-1:0][FLIT_W-1:0]      data_i,
    output logic                              rec_valid,
    input  logic                              rec_ready,
    output logic [$clog2(NPORT)-1:0]          rec_src,
    output logic [$clog2(NPORT)-1:0]          rec_dst,
    output logic [FLIT_W-1:0]                 rec_addr,
    output logic [FLIT_W-1:0]                 rec_data,
    output logic [TS_W-1:0]                   rec_lat,
    output logic [15:0]                       drop_count
);

    localparam int PW = $clog2(NPORT);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef struct packed {
        logic [PW-1:0]     src;
        logic [PW-1:0]     dst;
        logic [FLIT_W-1:0] addr;
        logic [FLIT_W-1:0] data;
        logic [TS_W-1:0]   lat;
    } rec_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_HDR,
        T_SIZE,
        T_PAY
    } trk_state_t;

    // Saturating add used by the drop counter so it sticks at all-ones.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [PW:0] b);
        logic [16:0] s;
        s = {1'b0, a} + 17'(b);
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    // Free-running timestamp and registered copy of the allocation flags.
    logic [TS_W-1:0]  ts_q;
    logic [NPORT-1:0] free_r;

    // Grant detection.
    logic [NPORT-1:0] grant_vec;
    logic             grant_ok;
    logic [PW-1:0]    grant_port;
    logic [NPORT-1:0] xfer;

    // Per-output trackers.
    trk_state_t        state_q [NPORT];
    trk_state_t        state_d [NPORT];
    logic [8:0]        cnt_q   [NPORT];
    logic [8:0]        cnt_d   [NPORT];
    logic [7:0]        size_q  [NPORT];
    logic [7:0]        size_d  [NPORT];
    logic [PW-1:0]     src_q   [NPORT];
    logic [PW-1:0]     src_d   [NPORT];
    logic [FLIT_W-1:0] addr_q  [NPORT];
    logic [FLIT_W-1:0] addr_d  [NPORT];
    logic [FLIT_W-1:0] cap_q   [NPORT];
    logic [FLIT_W-1:0] cap_d   [NPORT];
    logic [TS_W-1:0]   gts_q   [NPORT];
    logic [TS_W-1:0]   gts_d   [NPORT];
    logic [NPORT-1:0]  done;
    rec_t              done_rec [NPORT];

    // Pending slots between trackers and FIFO.
    logic [NPORT-1:0]  pend_q;
    logic [NPORT-1:0]  pend_d;
    logic [NPORT-1:0]  pend_wr;
    rec_t              pend_rec_q [NPORT];
    logic [PW-1:0]     push_sel;
    logic              push_any;
    logic [PW:0]       drop_inc;

    // Record FIFO.
    rec_t              mem [FIFO_DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic              fifo_empty;
    logic              fifo_full;
    logic              pop;
    rec_t              head;

    assign xfer = tx_i & credit_i;

    // Timestamp counter and allocation history.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ts_q   <= '0;
            free_r <= '1;
        end else begin
            ts_q   <= ts_q + 1'b1;
            free_r <= free_i;
        end
    end

    // A falling free flag marks a new connection; lowest output wins if several fall.
    always_comb begin
        grant_vec  = free_r & ~free_i;
        grant_ok   = enable & (|h_ack) & (|grant_vec);
        grant_port = '0;
        for (int p = NPORT - 1; p >= 0; p--) begin
            if (grant_vec[p]) grant_port = PW'(p);
        end
    end

    // Tracker next-state: a grant restarts the tracker, otherwise follow transfers.
    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            state_d[p]  = state_q[p];
            cnt_d[p]    = cnt_q[p];
            size_d[p]   = size_q[p];
            src_d[p]    = src_q[p];
            addr_d[p]   = addr_q[p];
            cap_d[p]    = cap_q[p];
            gts_d[p]    = gts_q[p];
            done[p]     = 1'b0;
            if (grant_ok && (grant_port == PW'(p))) begin
                state_d[p] = T_HDR;
                cnt_d[p]   = '0;
                src_d[p]   = in_port_i;
                addr_d[p]  = address_i;
                cap_d[p]   = '0;
                gts_d[p]   = ts_q;
            end else if (xfer[p]) begin
                case (state_q[p])
                    T_HDR: begin
                        state_d[p] = T_SIZE;
                        cnt_d[p]   = 9'd1;
                    end
                    T_SIZE: begin
                        size_d[p] = data_i[p][7:0];
                        if (data_i[p][7:0] == 8'd0) begin
                            done[p]    = 1'b1;
                            state_d[p] = T_IDLE;
                        end else begin
                            state_d[p] = T_PAY;
                            cnt_d[p]   = 9'd2;
                        end
                    end
                    T_PAY: begin
                        if (cnt_q[p] == 9'(CAPTURE_IDX)) cap_d[p] = data_i[p];
                        if (cnt_q[p] == ({1'b0, size_q[p]} + 9'd1)) begin
                            done[p]    = 1'b1;
                            state_d[p] = T_IDLE;
                        end else begin
                            cnt_d[p] = cnt_q[p] + 9'd1;
                        end
                    end
                    default: state_d[p] = state_q[p];
                endcase
            end
            done_rec[p].src  = src_q[p];
            done_rec[p].dst  = PW'(p);
            done_rec[p].addr = addr_q[p];
            done_rec[p].data = cap_d[p];
            done_rec[p].lat  = ts_q - gts_q[p];
        end
    end

    // Tracker control state.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int p = 0; p < NPORT; p++) begin
                state_q[p] <= T_IDLE;
                cnt_q[p]   <= '0;
                size_q[p]  <= '0;
            end
        end else begin
            for (int p = 0; p < NPORT; p++) begin
                state_q[p] <= state_d[p];
                cnt_q[p]   <= cnt_d[p];
                size_q[p]  <= size_d[p];
            end
        end
    end

    // Tracker captured fields; only meaningful while the tracker is active.
    always_ff @(posedge clock) begin
        for (int p = 0; p < NPORT; p++) begin
            src_q[p]  <= src_d[p];
            addr_q[p] <= addr_d[p];
            cap_q[p]  <= cap_d[p];
            gts_q[p]  <= gts_d[p];
        end
    end

    // Push arbitration and pending-slot update; a slot freed by this cycle's push can take a new record.
    always_comb begin
        push_sel = '0;
        for (int p = NPORT - 1; p >= 0; p--) begin
            if (pend_q[p]) push_sel = PW'(p);
        end
        push_any = (|pend_q) && (!fifo_full || pop);
        pend_d   = pend_q;
        if (push_any) pend_d[push_sel] = 1'b0;
        pend_wr  = '0;
        drop_inc = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (done[p]) begin
                if (pend_d[p]) begin
                    drop_inc = drop_inc + (PW + 1)'(1);
                end else begin
                    pend_d[p]  = 1'b1;
                    pend_wr[p] = 1'b1;
                end
            end
        end
    end

    // Pending flags and drop counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_q     <= '0;
            drop_count <= '0;
        end else begin
            pend_q     <= pend_d;
            drop_count <= sat_add16(drop_count, drop_inc);
        end
    end

    // Pending record contents.
    always_ff @(posedge clock) begin
        for (int p = 0; p < NPORT; p++) begin
            if (pend_wr[p]) pend_rec_q[p] <= done_rec[p];
        end
    end

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = !fifo_empty && rec_ready;
    assign head       = mem[rd_ptr[AW-1:0]];

    // FIFO pointers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_any) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // FIFO storage.
    always_ff @(posedge clock) begin
        if (push_any) mem[wr_ptr[AW-1:0]] <= pend_rec_q[push_sel];
    end

    // Outputs read zero whenever nothing is buffered, so reset and empty look alike.
    assign rec_valid = !fifo_empty;
    assign rec_src   = rec_valid ? head.src  : '0;
    assign rec_dst   = rec_valid ? head.dst  : '0;
    assign rec_addr  = rec_valid ? head.addr : '0;
    assign rec_data  = rec_valid ? head.data : '0;
    assign rec_lat   = rec_valid ? head.lat  : '0;

endmodule

// File: tb/tb_path_trace_monitor.sv
// Testbench for path_trace_monitor: directed packets, scoreboard of expected records,
// separate monitor popping and comparing each record the DUT hands over.
module tb_path_trace_monitor;

    logic              clock;
    logic              reset;
    logic              enable;
    logic [4:0]        h_ack;
    logic [2:0]        in_port_i;
    logic [15:0]       address_i;
    logic [4:0]        free_i;
    logic [4:0]        tx_i;
    logic [4:0]        credit_i;
    logic [4:0][15:0]  data_i;
    logic              rec_valid;
    logic              rec_ready;
    logic [2:0]        rec_src;
    logic [2:0]        rec_dst;
    logic [15:0]       rec_addr;
    logic [15:0]       rec_data;
    logic [15:0]       rec_lat;
    logic [15:0]       drop_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [53:0] exp_q[$];

    path_trace_monitor dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .h_ack      (h_ack),
        .in_port_i  (in_port_i),
        .address_i  (address_i),
        .free_i     (free_i),
        .tx_i       (tx_i),
        .credit_i   (credit_i),
        .data_i     (data_i),
        .rec_valid  (rec_valid),
        .rec_ready  (rec_ready),
        .rec_src    (rec_src),
        .rec_dst    (rec_dst),
        .rec_addr   (rec_addr),
        .rec_data   (rec_data),
        .rec_lat    (rec_lat),
        .drop_count (drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_rec(input int src, input int dst, input logic [15:0] addr,
                              input logic [15:0] data, input logic [15:0] lat);
        exp_q.push_back({3'(src), 3'(dst), addr, data, lat});
    endtask

    task automatic grant(input int src, input int dst, input logic [15:0] addr);
        free_i[dst]  = 1'b0;
        h_ack        = '0;
        h_ack[src]   = 1'b1;
        in_port_i    = 3'(src);
        address_i    = addr;
        tick();
        h_ack        = '0;
    endtask

    task automatic flit(input int dst, input logic [15:0] v, input logic cr);
        tx_i[dst]     = 1'b1;
        credit_i[dst] = cr;
        data_i[dst]   = v;
        tick();
        tx_i[dst]     = 1'b0;
        credit_i[dst] = 1'b1;
    endtask

    task automatic release_port(input int dst);
        free_i[dst] = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick();
            k++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: every record the DUT hands over is compared against the scoreboard head.
    always @(negedge clock) begin
        if (reset && rec_valid && rec_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_record", {10'd0, rec_src, rec_dst, rec_addr, rec_data, rec_lat}, 64'd0);
            end else begin
                check("record", {10'd0, rec_src, rec_dst, rec_addr, rec_data, rec_lat},
                      {10'd0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        reset     = 1'b0;
        enable    = 1'b1;
        h_ack     = '0;
        in_port_i = '0;
        address_i = '0;
        free_i    = '1;
        tx_i      = '0;
        credit_i  = '1;
        data_i    = '0;
        rec_ready = 1'b1;
        #12;
        check("reset_rec_valid", 64'(rec_valid), 64'd0);
        check("reset_rec_fields", {10'd0, rec_src, rec_dst, rec_addr, rec_data, rec_lat}, 64'd0);
        check("reset_drop_count", 64'(drop_count), 64'd0);
        @(posedge clock);
        #1 reset = 1'b1;
        tick();
        tick();

        // Single packet L->E, one flit per cycle.
        expect_rec(4, 0, 16'h0102, 16'hBBBB, 16'd5);
        grant(4, 0, 16'h0102);
        flit(0, 16'h0102, 1'b1);
        flit(0, 16'h0003, 1'b1);
        flit(0, 16'hAAAA, 1'b1);
        flit(0, 16'hBBBB, 1'b1);
        flit(0, 16'hCCCC, 1'b1);
        release_port(0);
        wait_drain("drain_single", 20);

        // size=0 and size=1 packets capture nothing.
        expect_rec(1, 2, 16'h0210, 16'h0000, 16'd2);
        grant(1, 2, 16'h0210);
        flit(2, 16'h0210, 1'b1);
        flit(2, 16'h0000, 1'b1);
        release_port(2);
        expect_rec(2, 3, 16'h0311, 16'h0000, 16'd3);
        grant(2, 3, 16'h0311);
        flit(3, 16'h0311, 1'b1);
        flit(3, 16'h0001, 1'b1);
        flit(3, 16'h5555, 1'b1);
        release_port(3);
        wait_drain("drain_short", 20);

        // Backpressure during payload: credit 1,0,1,0,1.
        expect_rec(4, 0, 16'h0102, 16'hBBBB, 16'd7);
        grant(4, 0, 16'h0102);
        flit(0, 16'h0102, 1'b1);
        flit(0, 16'h0003, 1'b1);
        flit(0, 16'hAAAA, 1'b1);
        flit(0, 16'hBBBB, 1'b0);
        flit(0, 16'hBBBB, 1'b1);
        flit(0, 16'hCCCC, 1'b0);
        flit(0, 16'hCCCC, 1'b1);
        release_port(0);
        wait_drain("drain_backpressure", 20);

        // Simultaneous completion on outputs 1 and 3.
        expect_rec(0, 1, 16'h1100, 16'h1333, 16'd5);
        expect_rec(2, 3, 16'h3300, 16'h3333, 16'd4);
        grant(0, 1, 16'h1100);
        grant(2, 3, 16'h3300);
        tx_i[1] = 1'b1; tx_i[3] = 1'b1;
        data_i[1] = 16'h1100; data_i[3] = 16'h3300; tick();
        data_i[1] = 16'h0002; data_i[3] = 16'h0002; tick();
        data_i[1] = 16'h1222; data_i[3] = 16'h3222; tick();
        data_i[1] = 16'h1333; data_i[3] = 16'h3333; tick();
        tx_i[1] = 1'b0; tx_i[3] = 1'b0;
        tick();
        check("simul_first_valid", 64'(rec_valid), 64'd1);
        check("simul_first_src", 64'(rec_src), 64'd0);
        tick();
        check("simul_second_src", 64'(rec_src), 64'd2);
        free_i[1] = 1'b1; free_i[3] = 1'b1;
        check("simul_drop_count", 64'(drop_count), 64'd0);
        wait_drain("drain_simul", 20);

        // Overflow: 10 packets with the consumer stalled.
        rec_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i < 9) expect_rec(4, 0, 16'h0A00 + 16'(i), 16'h0000, 16'd2);
            grant(4, 0, 16'h0A00 + 16'(i));
            flit(0, 16'h0A00 + 16'(i), 1'b1);
            flit(0, 16'h0000, 1'b1);
            release_port(0);
        end
        tick();
        check("overflow_drop_count", 64'(drop_count), 64'd1);
        check("overflow_head_addr", 64'(rec_addr), 64'h0A00);
        rec_ready = 1'b1;
        wait_drain("drain_overflow", 40);
        check("overflow_drop_after", 64'(drop_count), 64'd1);

        // No grant accepted while disabled, nor with h_ack idle.
        enable = 1'b0;
        grant(4, 0, 16'h0E00);
        flit(0, 16'h0E00, 1'b1);
        flit(0, 16'h0000, 1'b1);
        release_port(0);
        enable = 1'b1;
        free_i[0] = 1'b0;
        tick();
        flit(0, 16'h0E01, 1'b1);
        flit(0, 16'h0000, 1'b1);
        release_port(0);
        tick();
        tick();
        check("ignored_grants_valid", 64'(rec_valid), 64'd0);

        // Reset mid-payload with a record parked in the FIFO.
        rec_ready = 1'b0;
        grant(1, 2, 16'h2200);
        flit(2, 16'h2200, 1'b1);
        flit(2, 16'h0000, 1'b1);
        release_port(2);
        tick();
        check("parked_valid", 64'(rec_valid), 64'd1);
        grant(4, 0, 16'h0102);
        flit(0, 16'h0102, 1'b1);
        flit(0, 16'h0003, 1'b1);
        flit(0, 16'hAAAA, 1'b1);
        reset  = 1'b0;
        free_i = '1;
        tx_i   = '0;
        #2;
        check("midreset_valid", 64'(rec_valid), 64'd0);
        check("midreset_drop_count", 64'(drop_count), 64'd0);
        tick();
        reset     = 1'b1;
        rec_ready = 1'b1;
        tick();
        expect_rec(4, 0, 16'h0102, 16'hBBBB, 16'd5);
        grant(4, 0, 16'h0102);
        flit(0, 16'h0102, 1'b1);
        flit(0, 16'h0003, 1'b1);
        flit(0, 16'hAAAA, 1'b1);
        flit(0, 16'hBBBB, 1'b1);
        flit(0, 16'hCCCC, 1'b1);
        release_port(0);
        wait_drain("drain_after_reset", 20);
        tick();
        check("final_valid", 64'(rec_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
